// File: rtl/wasm_pkg.sv
// Shared constants for the wasm boot path: section IDs,
// code base and default boot ROM geometry.
package wasm_pkg;

  localparam logic [7:0] CODE_BASE = 8'h30;

  localparam logic [7:0] SEC_CUSTOM   = 8'h00;
  localparam logic [7:0] SEC_TYPE     = 8'h01;
  localparam logic [7:0] SEC_IMPORT   = 8'h02;
  localparam logic [7:0] SEC_FUNCTION = 8'h03;
  localparam logic [7:0] SEC_TABLE    = 8'h04;
  localparam logic [7:0] SEC_MEMORY   = 8'h05;
  localparam logic [7:0] SEC_GLOBAL   = 8'h06;
  localparam logic [7:0] SEC_EXPORT   = 8'h07;
  localparam logic [7:0] SEC_START    = 8'h08;
  localparam logic [7:0] SEC_ELEMENT  = 8'h09;
  localparam logic [7:0] SEC_CODE     = 8'h0A;
  localparam logic [7:0] SEC_DATA     = 8'h0B;
  localparam logic [7:0] SEC_DATACNT  = 8'h0C;

  localparam int unsigned ROM_BYTES_DEF = 4096;
  localparam int unsigned MEM_AW_DEF    = 14;

  function automatic logic [7:0] sel_byte(
    input logic [31:0] w,
    input logic [1:0]  b
  );
    return w[8*b +: 8];
  endfunction

endpackage

// File: rtl/bootrom_responder.sv
// Byte-wide boot ROM read port backed by a word store,
// with a one-word line buffer in front of it.
module bootrom_responder
  import wasm_pkg::*;
#(
  parameter int unsigned ROM_BYTES = ROM_BYTES_DEF,
  parameter int unsigned MEM_AW    = MEM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rom_addr,
  input  logic              rom_read_en,
  output logic [7:0]        rom_data_out,
  output logic              rom_ready,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_word_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              rom_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RESP,
    S_GAP,
    S_DRAIN
  } state_e;

  localparam logic [31:0] ROM_LIMIT = 32'(ROM_BYTES);

  state_e      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [29:0] tag_q, tag_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic        oor_q, oor_d;
  logic        err_q, err_d;
  logic [1:0]  drain_q, drain_d;

  logic in_range;
  logic hit;
  logic drain_done;

  assign in_range   = rom_addr < ROM_LIMIT;
  assign hit        = valid_q && (tag_q == rom_addr[31:2]);
  assign drain_done = mem_rvalid || (drain_q == 2'd3);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    oor_d   = oor_q;
    err_d   = err_q;
    drain_d = drain_q;

    if (rst) begin
      valid_d = 1'b0;
      addr_d  = '0;
      oor_d   = 1'b0;
      err_d   = 1'b0;
      // an in-flight word read must be soaked up before reuse
      unique case (state_q)
        S_FETCH: begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
        S_DRAIN: begin
          if (drain_done) state_d = S_IDLE;
          else drain_d = drain_q + 2'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rom_read_en) begin
            addr_d = rom_addr;
            oor_d  = !in_range;
            if (!in_range) begin
              err_d   = 1'b1;
              state_d = S_RESP;
            end else if (hit) begin
              state_d = S_RESP;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (mem_rvalid) begin
            buf_d   = mem_rdata;
            tag_d   = addr_q[31:2];
            valid_d = 1'b1;
            state_d = rom_read_en ? S_RESP : S_GAP;
          end
        end
        S_RESP: state_d = S_GAP;
        S_GAP:  state_d = S_IDLE;
        S_DRAIN: begin
          if (drain_done) state_d = S_IDLE;
          else drain_d = drain_q + 2'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    buf_q   <= buf_d;
    tag_q   <= tag_d;
    valid_q <= valid_d;
    addr_q  <= addr_d;
    oor_q   <= oor_d;
    err_q   <= err_d;
    drain_q <= drain_d;
  end

  assign rom_ready     = (state_q == S_RESP);
  assign rom_data_out  = (rom_ready && !oor_q)
                         ? sel_byte(buf_q, addr_q[1:0])
                         : 8'h00;
  assign mem_req       = (state_q == S_FETCH);
  assign mem_word_addr = addr_q[MEM_AW+1:2];
  assign rom_err       = err_q;

endmodule

// File: tb/tb_bootrom_responder.sv
// Directed bench for bootrom_responder with a
// latency-programmable backing-store model.
module tb_bootrom_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_addr = '0;
  logic        rom_read_en = 1'b0;
  logic [7:0]  rom_data_out;
  logic        rom_ready;
  logic        mem_req;
  logic [13:0] mem_word_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rom_err;

  int n_assert = 0;
  int n_fail   = 0;
  int bursts   = 0;
  int readies  = 0;
  logic req_prev = 1'b0;
  bit mem_auto = 1'b1;
  int mem_lat  = 2;
  int wait_cnt = 0;

  always #5 clk = ~clk;

  bootrom_responder #(
    .ROM_BYTES(4096),
    .MEM_AW(14)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rom_addr(rom_addr),
    .rom_read_en(rom_read_en),
    .rom_data_out(rom_data_out),
    .rom_ready(rom_ready),
    .mem_req(mem_req),
    .mem_word_addr(mem_word_addr),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .rom_err(rom_err)
  );

  function automatic logic [31:0] mem_word(input logic [13:0] wa);
    case (wa)
      14'd0:    return 32'hAABBCCDD;
      14'd1:    return 32'h11223344;
      14'd2:    return 32'h55667788;
      14'd4:    return 32'h99AABBCC;
      14'd8:    return 32'h0F1E2D3C;
      14'd1023: return 32'hDEADBEEF;
      default:  return {2'b00, wa, ~{2'b00, wa}};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_req && !req_prev) bursts++;
    req_prev = mem_req;
    if (rom_ready) readies++;
  end

  always @(negedge clk) begin
    if (!mem_auto) begin
      wait_cnt = 0;
    end else if (mem_rvalid) begin
      mem_rvalid = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      wait_cnt++;
      if (wait_cnt >= mem_lat) begin
        mem_rvalid = 1'b1;
        mem_rdata = mem_word(mem_word_addr);
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_read(
    input string tag,
    input logic [31:0] a,
    input logic [7:0] exp_d,
    input int exp_lat
  );
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    rom_addr = a;
    rom_read_en = 1'b1;
    for (int i = 1; i <= 20 && !got; i++) begin
      step();
      if (rom_ready) begin
        got = 1'b1;
        lat = i;
      end else if (mem_req) begin
        chk({tag, "_waddr"}, 32'(mem_word_addr), 32'(a[15:2]));
      end
    end
    rom_read_en = 1'b0;
    chk({tag, "_ready"}, 32'(got), 32'd1);
    chk({tag, "_data"}, 32'(rom_data_out), 32'(exp_d));
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    step();
    chk({tag, "_gap"}, {23'd0, rom_ready, rom_data_out}, 32'd0);
    step();
  endtask

  logic [7:0] stream_exp [8];
  int b0, r0, cnt;
  logic [31:0] a;
  bit got;

  initial begin
    stream_exp = '{8'h44, 8'h33, 8'h22, 8'h11,
                   8'h88, 8'h77, 8'h66, 8'h55};

    rst = 1'b1;
    repeat (2) step();
    chk("rst_ready", 32'(rom_ready), 32'd0);
    chk("rst_data", 32'(rom_data_out), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_waddr", 32'(mem_word_addr), 32'd0);
    chk("rst_err", 32'(rom_err), 32'd0);
    rst = 1'b0;
    step();

    b0 = bursts;
    do_read("cold0", 32'd0, 8'hDD, 3);
    do_read("cold1", 32'd1, 8'hCC, 1);
    do_read("cold2", 32'd2, 8'hBB, 1);
    do_read("cold3", 32'd3, 8'hAA, 1);
    chk("cold_bursts", 32'(bursts - b0), 32'd1);

    b0 = bursts;
    do_read("hit2", 32'd2, 8'hBB, 1);
    chk("hit_bursts", 32'(bursts - b0), 32'd0);

    b0 = bursts;
    r0 = readies;
    cnt = 0;
    a = 32'd4;
    rom_addr = a;
    rom_read_en = 1'b1;
    for (int i = 0; i < 200 && cnt < 8; i++) begin
      step();
      if (rom_ready) begin
        chk($sformatf("stream%0d", cnt), 32'(rom_data_out),
            32'(stream_exp[cnt]));
        cnt++;
        a = a + 32'd1;
        rom_addr = a;
        if (cnt == 8) rom_read_en = 1'b0;
        step();
        chk("stream_gap", 32'(rom_ready), 32'd0);
      end
    end
    step();
    chk("stream_cnt", 32'(cnt), 32'd8);
    chk("stream_bursts", 32'(bursts - b0), 32'd2);
    chk("stream_pulses", 32'(readies - r0), 32'd8);

    do_read("top", 32'd4095, 8'hDE, 3);
    chk("top_err", 32'(rom_err), 32'd0);
    b0 = bursts;
    do_read("oor", 32'd4096, 8'h00, 1);
    chk("oor_err", 32'(rom_err), 32'd1);
    do_read("alias", 32'h0001_0008, 8'h00, 1);
    do_read("maxaddr", 32'hFFFF_FFFF, 8'h00, 1);
    do_read("hit_top", 32'd4094, 8'hAD, 1);
    chk("oor_sticky", 32'(rom_err), 32'd1);
    chk("oor_bursts", 32'(bursts - b0), 32'd0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst_err_clr", 32'(rom_err), 32'd0);
    b0 = bursts;
    do_read("after_rst", 32'd4094, 8'hAD, 3);
    chk("after_rst_bursts", 32'(bursts - b0), 32'd1);

    rom_addr = 32'h30;
    rom_read_en = 1'b1;
    step();
    rom_addr = 32'h44;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (mem_req) chk("latch_waddr", 32'(mem_word_addr), 32'd12);
      step();
      if (rom_ready) got = 1'b1;
    end
    rom_read_en = 1'b0;
    chk("latch_ready", 32'(got), 32'd1);
    chk("latch_data", 32'(rom_data_out), 32'h0000_00F3);
    repeat (2) step();

    mem_lat = 4;
    b0 = bursts;
    r0 = readies;
    rom_addr = 32'h10;
    rom_read_en = 1'b1;
    repeat (2) step();
    chk("abort_req", 32'(mem_req), 32'd1);
    rom_read_en = 1'b0;
    repeat (8) step();
    chk("abort_ready", 32'(readies - r0), 32'd0);
    chk("abort_req_done", 32'(mem_req), 32'd0);
    mem_lat = 2;
    do_read("abort_hit", 32'h11, 8'hBB, 1);
    chk("abort_bursts", 32'(bursts - b0), 32'd1);

    mem_auto = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    step();
    mem_auto = 1'b1;
    do_read("stray_idle", 32'h12, 8'hAA, 1);

    mem_auto = 1'b0;
    r0 = readies;
    rom_addr = 32'h20;
    rom_read_en = 1'b1;
    repeat (2) step();
    chk("rf_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    rom_read_en = 1'b0;
    step();
    chk("rf_req_drop", 32'(mem_req), 32'd0);
    rst = 1'b0;
    step();
    mem_rdata = 32'h1234_5678;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    step();
    chk("rf_no_ready", 32'(readies - r0), 32'd0);
    mem_auto = 1'b1;
    b0 = bursts;
    do_read("rf_fresh", 32'h20, 8'h3C, 3);
    chk("rf_bursts", 32'(bursts - b0), 32'd1);

    mem_auto = 1'b0;
    rom_addr = 32'h24;
    rom_read_en = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    rom_read_en = 1'b0;
    step();
    rst = 1'b0;
    repeat (6) step();
    chk("to_req", 32'(mem_req), 32'd0);
    mem_auto = 1'b1;
    b0 = bursts;
    do_read("to_fresh", 32'h24, 8'hF6, 3);
    chk("to_bursts", 32'(bursts - b0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bootrom_responder.md
BOOTROM_RESPONDER -- requirements
Module: bootrom_responder

Interface
REQ-001 Parameter ROM_BYTES, default 4096, ROM size in bytes; a multiple of 4, at most 2^16.
REQ-002 Parameter MEM_AW, default 14, backing-store word address width.
REQ-003 Clocking: one clock, clk. Reset rst is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rom_addr  in  32  byte address from the loader; valid while rom_read_en=1.
REQ-007 rom_read_en  in  1  loader read request; level, held until served.
REQ-008 rom_data_out  out  8  returned byte; valid only while rom_ready=1.
REQ-009 rom_ready  out  1  one-cycle pulse; read complete.
REQ-010 mem_req  out  1  backing-store word read request; held until mem_rvalid.
REQ-011 mem_word_addr  out  MEM_AW  word address, equal to rom_addr[MEM_AW+1:2]; stable while mem_req=1.
REQ-012 mem_rvalid  in  1  backing-store data valid; one-cycle pulse.
REQ-013 mem_rdata  in  32  little-endian word.
REQ-014 rom_err  out  1  sticky out-of-range-access flag.

Function
REQ-015 FSM states: IDLE, FETCH, RESP, GAP, DRAIN.
REQ-016 Line buffer: one 32-bit word, one tag (word address), one valid bit.
REQ-017 IDLE, rom_read_en=1, in range, hit (valid and tag match): next state RESP; rom_ready=1 in the following cycle (1-cycle latency).
REQ-018 IDLE, rom_read_en=1, in range, miss: next state FETCH; mem_req=1 from the next cycle; rom_addr is latched, and later changes are ignored.
REQ-019 FETCH, mem_rvalid=1 in cycle u: load the buffer, set tag and valid, drop mem_req, go to RESP; rom_ready=1 in cycle u+1.
REQ-020 FETCH, rom_read_en already 0 when mem_rvalid arrives: load the buffer, go directly to GAP, no rom_ready pulse.
REQ-021 Byte select: rom_data_out = buffer[8*a[1:0]+7 : 8*a[1:0]], where a is the latched address.
REQ-022 Out of range (rom_addr >= ROM_BYTES): no mem_req; RESP next cycle with rom_data_out=8'h00; rom_err set to 1.
REQ-023 RESP lasts exactly one cycle with rom_ready=1, then GAP.
REQ-024 GAP lasts exactly one cycle with rom_ready=0, then IDLE. This guarantees the loader a cycle to present a new address.
REQ-025 Loader holding rom_read_en=1 with an incremented address across GAP is a new request, sampled in IDLE.
REQ-026 rom_ready is 0 in every state except RESP; rom_data_out=8'h00 whenever rom_ready=0.
REQ-027 mem_rvalid outside FETCH/DRAIN is ignored: no buffer update.
REQ-028 Address arithmetic: range compare uses all 32 bits; no wrap-around; bits above MEM_AW+1 do not alias.

Reset
REQ-029 rst=1: state IDLE, valid=0, rom_ready=0, rom_data_out=0, mem_req=0, mem_word_addr=0, rom_err=0.
REQ-030 Reset during FETCH: mem_req drops in the next cycle. The FSM enters DRAIN and waits for one stray mem_rvalid, or 4 cycles, before IDLE. The stray word is discarded.

Structure
REQ-031 Shared package wasm_pkg holds CODE_BASE (8'h30), the section ID constants, and the default ROM_BYTES. The FSM encoding stays local.
REQ-032 No sub-module; the line buffer is inline.

Verification
REQ-033 Cold miss: mem returns 32'hAABBCCDD for word 0 with 2-cycle latency; reading addr 0..3 -> bytes DD, CC, BB, AA; exactly one mem_req burst.
REQ-034 Hit timing: after REQ-033, read addr 2 -> rom_ready exactly 1 cycle after IDLE sample, data BB, mem_req stays 0.
REQ-035 Streamed read: read_en held high, addr incremented on each ready cycle for 8 bytes -> 8 pulses separated by GAP, 2 mem fetches.
REQ-036 Out of range: addr 4096 (ROM_BYTES=4096) -> rom_ready with data 00, rom_err=1 until rst, no mem_req.
REQ-037 Abort: read_en drops during FETCH -> no rom_ready; a later read of the same word hits.
REQ-038 Reset mid-FETCH: rst pulsed, then late mem_rvalid -> buffer invalid; next read of that word issues a fresh mem_req.
